miriscv_mem_arbiter: RTL and testbench

- Shares one data-memory slave port between two requesters: master 0 is the core LSU data port and master 1 is the DMA/debug port.
- Uses round-robin arbitration with a req/gnt/rvalid handshake.
- Allows at most one outstanding transaction, with a response timeout.
- Sits between the core's data_* bus, the DMA engine and the data memory.

---
 rtl/miriscv_arb_pkg.sv | 7 +
 rtl/miriscv_rr_arb2.sv | 12 +
 rtl/miriscv_mem_arbiter.sv | 72 +++++++
 tb/tb_miriscv_mem_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_arb_pkg.sv
// miriscv_arb_pkg: shared encodings and defaults for the data-memory arbiter
package miriscv_arb_pkg;
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  localparam logic M_CORE = 1'b0;
  localparam logic M_DMA = 1'b1;
  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/miriscv_rr_arb2.sv
// miriscv_rr_arb2: combinational 2-way round-robin pick, the master that did not go last wins a tie
module miriscv_rr_arb2
  import miriscv_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);
  assign any = |req;
  assign winner = (&req) ? ~last : (req[1] ? M_DMA : M_CORE);
endmodule

// File: rtl/miriscv_mem_arbiter.sv
// miriscv_mem_arbiter: shares one data-memory slave between core LSU and DMA, one outstanding transaction with timeout
module miriscv_mem_arbiter
  import miriscv_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_i,
  input  logic [1:0]  we_i,
  input  logic [7:0]  be_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  rvalid_o,
  output logic [1:0]  err_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  state_t r_state, w_state_nxt;
  logic r_owner, r_last;
  logic [7:0] r_cnt;
  logic w_win, w_any, w_idle, w_wait, w_fire, w_tout, w_resp, w_dma;
  logic [1:0] w_own_oh;
  miriscv_rr_arb2 u_arb (.req(req_i), .last(r_last), .winner(w_win), .any(w_any));
  // every output path is qualified by ~reset so the port is quiet while reset is held
  assign w_idle = (r_state == ST_IDLE) & ~reset;
  assign w_wait = (r_state == ST_WAIT) & ~reset;
  assign w_fire = w_idle & w_any & mem_gnt_i;
  assign w_tout = w_wait & ~mem_rvalid_i & (r_cnt == CNT_LAST);
  assign w_resp = w_wait & (mem_rvalid_i | w_tout);
  assign w_dma = (w_win == M_DMA);
  assign w_own_oh = {r_owner, ~r_owner};
  assign mem_req_o = w_idle & w_any;
  assign mem_we_o = mem_req_o & (w_dma ? we_i[1] : we_i[0]);
  assign mem_be_o = mem_req_o ? (w_dma ? be_i[7:4] : be_i[3:0]) : 4'h0;
  assign mem_addr_o = mem_req_o ? (w_dma ? addr_i[63:32] : addr_i[31:0]) : 32'h0;
  assign mem_wdata_o = mem_req_o ? (w_dma ? wdata_i[63:32] : wdata_i[31:0]) : 32'h0;
  assign gnt_o = {w_fire & w_dma, w_fire & ~w_dma};
  assign rvalid_o = w_resp ? w_own_oh : 2'b00;
  assign err_o = w_tout ? w_own_oh : 2'b00;
  assign rdata_o = w_tout ? ERR_RDATA : (w_resp ? mem_rdata_i : 32'h0);
  always_comb begin
    w_state_nxt = w_fire ? ST_WAIT : (w_resp ? ST_IDLE : r_state);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= M_CORE;
      r_last <= M_DMA;
      r_cnt <= 8'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        r_owner <= w_win;
        r_cnt <= 8'h0;
      end else if (w_wait && r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'h1;
      end
      if (w_resp) r_last <= r_owner;
    end
  end
endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// tb_miriscv_mem_arbiter: directed vectors for the two-master data-memory arbiter
module tb_miriscv_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] req_i, we_i, gnt_o, rvalid_o, err_o;
  logic [7:0] be_i;
  logic [63:0] addr_i, wdata_i;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [3:0] mem_be_o;
  int n_tests = 0;
  int n_fail = 0;
  miriscv_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    req_i = 2'b00;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    step();
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    req_i = 2'b11;
    we_i = 2'b11;
    be_i = 8'hFF;
    addr_i = {32'h0000_2000, 32'h0000_1000};
    wdata_i = 64'h0;
    mem_gnt_i = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h0000_0123;
    settle();
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_mem_req", 32'(mem_req_o), 32'h0);
    check("rst_rvalid", 32'(rvalid_o), 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_addr", mem_addr_o, 32'h0);
    step();
    step();
    reset = 1'b0;
    req_i = 2'b01;
    we_i = 2'b00;
    mem_rvalid_i = 1'b0;
    addr_i = {32'h0, 32'h0000_0100};
    mem_gnt_i = 1'b1;
    settle();
    check("rd_gnt", 32'(gnt_o), 32'h1);
    check("rd_mem_req", 32'(mem_req_o), 32'h1);
    check("rd_addr", mem_addr_o, 32'h100);
    check("rd_we", 32'(mem_we_o), 32'h0);
    step();
    req_i = 2'b00;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h1234_5678;
    settle();
    check("rd_rvalid", 32'(rvalid_o), 32'h1);
    check("rd_rdata", rdata_o, 32'h1234_5678);
    check("rd_err", 32'(err_o), 32'h0);
    check("rd_wait_req", 32'(mem_req_o), 32'h0);
    step();
    mem_rvalid_i = 1'b0;
    settle();
    check("idle_rdata", rdata_o, 32'h0);
    check("idle_rvalid", 32'(rvalid_o), 32'h0);
    pulse_reset();
    addr_i = {32'h0000_2000, 32'h0000_1000};
    for (int i = 0; i < 4; i++) begin
      req_i = 2'b11;
      mem_gnt_i = 1'b1;
      mem_rvalid_i = 1'b0;
      settle();
      check($sformatf("rr_gnt%0d", i), 32'(gnt_o), (i % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr_addr%0d", i), mem_addr_o, (i % 2 == 0) ? 32'h1000 : 32'h2000);
      step();
      mem_rvalid_i = 1'b1;
      mem_rdata_i = 32'(i);
      settle();
      check($sformatf("rr_wait_gnt%0d", i), 32'(gnt_o), 32'h0);
      check($sformatf("rr_rvalid%0d", i), 32'(rvalid_o), (i % 2 == 0) ? 32'h1 : 32'h2);
      step();
    end
    mem_rvalid_i = 1'b0;
    req_i = 2'b10;
    we_i = 2'b10;
    be_i = {4'b0011, 4'b1111};
    addr_i = {32'h0000_0200, 32'h0000_0400};
    wdata_i = {32'hAAAA_5555, 32'h1111_1111};
    mem_gnt_i = 1'b1;
    settle();
    check("wr_gnt", 32'(gnt_o), 32'h2);
    check("wr_we", 32'(mem_we_o), 32'h1);
    check("wr_be", 32'(mem_be_o), 32'h3);
    check("wr_addr", mem_addr_o, 32'h200);
    check("wr_wdata", mem_wdata_o, 32'hAAAA_5555);
    step();
    req_i = 2'b00;
    we_i = 2'b00;
    mem_rvalid_i = 1'b1;
    settle();
    check("wr_rvalid", 32'(rvalid_o), 32'h2);
    step();
    mem_rvalid_i = 1'b0;
    req_i = 2'b01;
    addr_i = {32'h0, 32'h0000_0300};
    mem_gnt_i = 1'b1;
    settle();
    check("to_gnt", 32'(gnt_o), 32'h1);
    step();
    req_i = 2'b00;
    for (int k = 1; k < 4; k++) begin
      settle();
      check($sformatf("to_quiet%0d", k), 32'(rvalid_o), 32'h0);
      step();
    end
    settle();
    check("to_rvalid", 32'(rvalid_o), 32'h1);
    check("to_err", 32'(err_o), 32'h1);
    check("to_rdata", rdata_o, 32'hDEAD_BEEF);
    step();
    req_i = 2'b10;
    mem_gnt_i = 1'b0;
    settle();
    check("to_back_idle", 32'(mem_req_o), 32'h1);
    check("to_nogrant", 32'(gnt_o), 32'h0);
    mem_gnt_i = 1'b1;
    settle();
    check("race_gnt", 32'(gnt_o), 32'h2);
    step();
    req_i = 2'b00;
    step();
    step();
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hCAFE_0001;
    settle();
    check("race_rvalid", 32'(rvalid_o), 32'h2);
    check("race_err", 32'(err_o), 32'h0);
    check("race_rdata", rdata_o, 32'hCAFE_0001);
    step();
    mem_rvalid_i = 1'b0;
    req_i = 2'b01;
    mem_gnt_i = 1'b1;
    settle();
    check("rw_gnt", 32'(gnt_o), 32'h1);
    step();
    pulse_reset();
    mem_rvalid_i = 1'b1;
    settle();
    check("stray_rvalid", 32'(rvalid_o), 32'h0);
    check("stray_rdata", rdata_o, 32'h0);
    step();
    mem_rvalid_i = 1'b0;
    req_i = 2'b01;
    mem_gnt_i = 1'b1;
    settle();
    check("post_rst_gnt", 32'(gnt_o), 32'h1);
    step();
    req_i = 2'b00;
    mem_rvalid_i = 1'b1;
    settle();
    check("post_rst_rvalid", 32'(rvalid_o), 32'h1);
    step();
    mem_rvalid_i = 1'b0;
    step();
    pulse_reset();
    req_i = 2'b01;
    mem_gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("stall_gnt%0d", k), 32'(gnt_o), 32'h0);
      check($sformatf("stall_rvalid%0d", k), 32'(rvalid_o), 32'h0);
      step();
    end
    req_i = 2'b11;
    mem_gnt_i = 1'b1;
    settle();
    check("stall_win", 32'(gnt_o), 32'h1);
    step();
    req_i = 2'b00;
    mem_rvalid_i = 1'b1;
    settle();
    check("stall_rvalid", 32'(rvalid_o), 32'h1);
    step();
    mem_rvalid_i = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
